// File: rtl/ftof_rr_sched.sv
// Round-robin scheduler that shares one combinational int16->float32 converter between NUM_CH channels.
// Optional per-channel transfer counters and a converter-valid error flag are enabled by FTOF_SCHED_STATS_EN.
module ftof_rr_sched #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16,
    parameter int OUT_W  = 32,
    parameter int BURST  = 1,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH*DATA_W-1:0] req_data,
    output logic [NUM_CH-1:0]        req_ready,
    output logic [DATA_W-1:0]        cvt_data_in,
    output logic                     cvt_valid_in,
    input  logic [OUT_W-1:0]         cvt_data_out,
    input  logic                     cvt_valid_out,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     out_ready,
    output logic                     idle
`ifdef FTOF_SCHED_STATS_EN
    ,
    output logic [NUM_CH*16-1:0]     stat_cnt,
    output logic                     err_cvt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam logic [7:0] BURST_MAX = 8'(BURST);

    state_t          state_reg, state_next;
    logic            run;
    logic            slot_free;
    logic            burst_hold;
    logic            grant_ok;
    logic [CH_W-1:0] grant;
    logic [CH_W-1:0] last_grant_reg;
    logic [7:0]      burst_cnt_reg;

    assign slot_free = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (en) state_next = S_RUN;
            S_RUN:   if (!en) state_next = S_DRAIN;
            S_DRAIN: begin
                if (en)             state_next = S_RUN;
                else if (slot_free) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        run  = (state_reg == S_RUN);
        idle = (state_reg == S_IDLE) && !out_valid;
    end

    // The burst owner keeps the grant only while it still asks and has beats left.
    assign burst_hold = (burst_cnt_reg != 8'd0) && (burst_cnt_reg < BURST_MAX)
                        && req_valid[last_grant_reg];

    // Walk from the farthest candidate to the nearest so the nearest valid one wins.
    always_comb begin
        int cand;
        cand     = 0;
        grant    = last_grant_reg;
        grant_ok = 1'b0;
        if (run && slot_free) begin
            if (burst_hold) begin
                grant_ok = 1'b1;
            end else begin
                for (int k = NUM_CH; k >= 1; k--) begin
                    cand = int'(last_grant_reg) + k;
                    if (cand >= NUM_CH) cand = cand - NUM_CH;
                    if (req_valid[cand]) begin
                        grant    = CH_W'(cand);
                        grant_ok = 1'b1;
                    end
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
            assign req_ready[gi] = grant_ok && (grant == CH_W'(gi));
        end
    endgenerate

    assign cvt_valid_in = grant_ok;
    assign cvt_data_in  = grant_ok ? req_data[grant*DATA_W +: DATA_W] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_ch         <= '0;
            last_grant_reg <= CH_W'(NUM_CH - 1);
            burst_cnt_reg  <= 8'd0;
        end else if (grant_ok) begin
            out_valid      <= 1'b1;
            out_data       <= cvt_data_out;
            out_ch         <= grant;
            last_grant_reg <= grant;
            burst_cnt_reg  <= (grant == last_grant_reg && burst_cnt_reg < BURST_MAX)
                              ? burst_cnt_reg + 8'd1 : 8'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef FTOF_SCHED_STATS_EN
    logic [15:0] stat_reg [NUM_CH];
    logic        err_cvt_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_stat
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    stat_reg[gi] <= 16'h0000;
                else if (req_ready[gi] && req_valid[gi] && stat_reg[gi] != 16'hFFFF)
                    stat_reg[gi] <= stat_reg[gi] + 16'h0001;
            end
            assign stat_cnt[gi*16 +: 16] = stat_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          err_cvt_reg <= 1'b0;
        else if (cvt_valid_in && !cvt_valid_out) err_cvt_reg <= 1'b1;
    end
    assign err_cvt = err_cvt_reg;
`else
    // The converter is combinational, so its valid strobe carries no information here.
    logic cvt_valid_unused;
    assign cvt_valid_unused = cvt_valid_out;
`endif

endmodule

// File: tb/tb_ftof_rr_sched.sv
// Randomised and directed bench for ftof_rr_sched; two instances (BURST=1 and BURST=3) share the stimulus
// and are each checked against an arbitration/pipeline reference model.
module tb_ftof_rr_sched;
    localparam int N = 4;
    localparam int IDLE_S  = 0;
    localparam int RUN_S   = 1;
    localparam int DRAIN_S = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           out_ready = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*16-1:0] req_data = '0;

    logic [N-1:0]   rr  [2];
    logic [15:0]    cdi [2];
    logic           cvi [2];
    logic [31:0]    cdo [2];
    logic           ov  [2];
    logic [31:0]    od  [2];
    logic [1:0]     oc  [2];
    logic           idl [2];
`ifdef FTOF_SCHED_STATS_EN
    logic [N*16-1:0] sc [2];
    logic            ec [2];
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    // Reference model state
    int          m_st   [2];
    logic        m_ov   [2];
    logic [31:0] m_od   [2];
    int          m_och  [2];
    int          m_last [2];
    int          m_bcnt [2];
    int          burst_lim [2] = '{1, 3};

    always #5 clk = ~clk;

    // Q1.15 sample to IEEE-754 single (exact for every 16-bit input)
    function automatic logic [31:0] q15tof(input logic [15:0] x);
        int v, m, p, e, mant;
        logic [31:0] r;
        if (x == 16'h0000) return 32'h0;
        v = int'($signed(x));
        m = (v < 0) ? -v : v;
        p = 0;
        for (int b = 0; b < 17; b++) if (((m >> b) & 1) == 1) p = b;
        e    = 112 + p;
        mant = (m << (23 - p)) & 32'h007F_FFFF;
        r    = {x[15], e[7:0], mant[22:0]};
        return r;
    endfunction

    assign cdo[0] = q15tof(cdi[0]);
    assign cdo[1] = q15tof(cdi[1]);

    ftof_rr_sched #(.NUM_CH(N), .DATA_W(16), .OUT_W(32), .BURST(1)) u_dut_b1 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_data(req_data), .req_ready(rr[0]),
        .cvt_data_in(cdi[0]), .cvt_valid_in(cvi[0]),
        .cvt_data_out(cdo[0]), .cvt_valid_out(cvi[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_ch(oc[0]),
        .out_ready(out_ready), .idle(idl[0])
`ifdef FTOF_SCHED_STATS_EN
        , .stat_cnt(sc[0]), .err_cvt(ec[0])
`endif
    );

    ftof_rr_sched #(.NUM_CH(N), .DATA_W(16), .OUT_W(32), .BURST(3)) u_dut_b3 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_data(req_data), .req_ready(rr[1]),
        .cvt_data_in(cdi[1]), .cvt_valid_in(cvi[1]),
        .cvt_data_out(cdo[1]), .cvt_valid_out(cvi[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_ch(oc[1]),
        .out_ready(out_ready), .idle(idl[1])
`ifdef FTOF_SCHED_STATS_EN
        , .stat_cnt(sc[1]), .err_cvt(ec[1])
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = IDLE_S; m_ov[i] = 1'b0; m_od[i] = 32'h0;
            m_och[i] = 0; m_last[i] = N - 1; m_bcnt[i] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst.d%0d.out_valid", i), 32'(ov[i]), 32'h0);
            check($sformatf("rst.d%0d.out_data", i), od[i], 32'h0);
            check($sformatf("rst.d%0d.out_ch", i), 32'(oc[i]), 32'h0);
            check($sformatf("rst.d%0d.idle", i), 32'(idl[i]), 32'h1);
            check($sformatf("rst.d%0d.req_ready", i), 32'(rr[i]), 32'h0);
`ifdef FTOF_SCHED_STATS_EN
            check($sformatf("rst.d%0d.stat_lo", i), sc[i][31:0], 32'h0);
            check($sformatf("rst.d%0d.stat_hi", i), sc[i][63:32], 32'h0);
`endif
        end
        model_reset();
        en = 1'b0; req_valid = '0; out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive, compare against the model, then advance the model past the coming edge.
    task automatic step(input logic e, input logic [N-1:0] v, input logic [N*16-1:0] d, input logic ordy);
        int g, nst;
        logic hit, slot;
        logic [N-1:0] exp_rr;
        logic [15:0] exp_cdi;
        @(negedge clk);
        en = e; req_valid = v; req_data = d; out_ready = ordy;
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            slot = !m_ov[i] || ordy;
            hit = 1'b0;
            g = 0;
            if (m_st[i] == RUN_S && slot) begin
                if (m_bcnt[i] > 0 && m_bcnt[i] < burst_lim[i] && v[m_last[i]]) begin
                    g = m_last[i]; hit = 1'b1;
                end else begin
                    for (int k = 1; k <= N && !hit; k++) begin
                        if (v[(m_last[i] + k) % N]) begin
                            g = (m_last[i] + k) % N; hit = 1'b1;
                        end
                    end
                end
            end
            exp_rr = '0;
            if (hit) exp_rr[g] = 1'b1;
            exp_cdi = hit ? d[g*16 +: 16] : 16'h0;

            check($sformatf("c%0d.d%0d.req_ready", cyc, i), 32'(rr[i]), 32'(exp_rr));
            check($sformatf("c%0d.d%0d.cvt_valid_in", cyc, i), 32'(cvi[i]), 32'(hit));
            check($sformatf("c%0d.d%0d.cvt_data_in", cyc, i), 32'(cdi[i]), 32'(exp_cdi));
            check($sformatf("c%0d.d%0d.out_valid", cyc, i), 32'(ov[i]), 32'(m_ov[i]));
            check($sformatf("c%0d.d%0d.out_data", cyc, i), od[i], m_od[i]);
            check($sformatf("c%0d.d%0d.out_ch", cyc, i), 32'(oc[i]), 32'(m_och[i]));
            check($sformatf("c%0d.d%0d.idle", cyc, i), 32'(idl[i]),
                  32'(m_st[i] == IDLE_S && !m_ov[i]));

            nst = m_st[i];
            case (m_st[i])
                IDLE_S:  if (e) nst = RUN_S;
                RUN_S:   if (!e) nst = DRAIN_S;
                default: if (e) nst = RUN_S; else if (slot) nst = IDLE_S;
            endcase
            m_st[i] = nst;

            if (hit) begin
                m_od[i]   = q15tof(d[g*16 +: 16]);
                m_och[i]  = g;
                m_ov[i]   = 1'b1;
                m_bcnt[i] = (g == m_last[i] && m_bcnt[i] < burst_lim[i]) ? m_bcnt[i] + 1 : 1;
                m_last[i] = g;
                $display("cyc %0d dut%0d grant ch%0d in %h out %h", cyc, i, g, d[g*16 +: 16], m_od[i]);
            end else if (ordy) begin
                m_ov[i] = 1'b0;
            end
        end
    endtask

    localparam logic [N*16-1:0] D_MIX = {16'h0000, 16'h4000, 16'hC000, 16'h0001};
    localparam logic [N*16-1:0] D_CH2 = {16'h0000, 16'h4000, 16'h0000, 16'h0000};

    initial begin
        logic [31:0] held_d;
        logic [1:0]  held_c;
        int          seq3 [7] = '{1, 1, 1, 3, 3, 3, 1};
        logic [N*16-1:0] rd;

        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Single channel with the converter attached
        step(1'b1, 4'b0100, D_CH2, 1'b1);
        step(1'b1, 4'b0100, D_CH2, 1'b1);
        check("tp1.req_ready", 32'(rr[0]), 32'h4);
        step(1'b1, 4'b0000, D_CH2, 1'b1);
        check("tp1.out_valid", 32'(ov[0]), 32'h1);
        check("tp1.out_data", od[0], 32'h3F000000);
        check("tp1.out_ch", 32'(oc[0]), 32'h2);

        // All four channels requesting, full throughput
        repeat (10) step(1'b1, 4'b1111, D_MIX, 1'b1);

        // Back-pressure: held result must not move
        step(1'b1, 4'b1111, D_MIX, 1'b0);
        held_d = od[0];
        held_c = oc[0];
        repeat (5) begin
            step(1'b1, 4'b1111, D_MIX, 1'b0);
            check("tp4.hold_data", od[0], held_d);
            check("tp4.hold_ch", 32'(oc[0]), 32'(held_c));
            check("tp4.no_grant", 32'(rr[0]), 32'h0);
        end
        repeat (6) step(1'b1, 4'b1111, D_MIX, 1'b1);

        // Stop with a zero sample pending
        step(1'b1, 4'b1111, '0, 1'b1);
        step(1'b0, 4'b1111, '0, 1'b0);
        repeat (2) begin
            step(1'b0, 4'b1111, D_MIX, 1'b0);
            check("tp5.drain_no_grant", 32'(rr[0]), 32'h0);
            check("tp5.zero_data", od[0], 32'h0);
        end
        step(1'b0, 4'b1111, D_MIX, 1'b1);
        step(1'b0, 4'b1111, D_MIX, 1'b1);
        check("tp5.idle", 32'(idl[0]), 32'h1);

        // Reset in the middle of a stream
        repeat (3) step(1'b1, 4'b1111, D_MIX, 1'b1);
        do_reset();
        step(1'b1, 4'b0110, D_MIX, 1'b1);
        step(1'b1, 4'b0110, D_MIX, 1'b1);
        check("tp6.first_grant", 32'(rr[0]), 32'h2);

        // Burst of three on the BURST=3 instance
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, 4'b1010, D_MIX, 1'b1);
            if (k >= 3) check($sformatf("tp3.seq%0d", k - 3), 32'(oc[1]), 32'(seq3[k-3]));
        end
        step(1'b1, 4'b1010, D_MIX, 1'b1);
        step(1'b1, 4'b1000, D_MIX, 1'b1);
        repeat (3) step(1'b1, 4'b1010, D_MIX, 1'b1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rd = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rd[15:0] = 16'h8000;
            step(($urandom_range(0, 7) != 0), 4'($urandom), rd, ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
